// File: rtl/scsi_sector_bridge.sv
// Bridges SCSI target sector requests to a byte-addressed storage buffer port.
// A private 512-byte buffer lets each side move data at its own pace.
module scsi_sector_bridge #(
  parameter int unsigned STB_HI = 1,
  parameter int unsigned STB_LO = 1
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [31:0] io_lba,
  input  logic        io_rd,
  input  logic        io_wr,
  output logic        io_ack,
  output logic [7:0]  io_din,
  output logic        io_din_strobe,
  input  logic [7:0]  io_dout,
  output logic        io_dout_strobe,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_FILL, RD_STREAM, WR_DRAIN, WR_REQ, WR_SERVE, DONE, WAIT_CLR
  } state_t;

  // Strobe slot phases: reads are low-then-high, writes are high-then-low.
  localparam logic [15:0] RD_RISE   = 16'(STB_LO - 1);
  localparam logic [15:0] WR_FALL   = 16'(STB_HI - 1);
  localparam logic [15:0] WR_SAMPLE = 16'(STB_HI);
  localparam logic [15:0] SLOT_END  = 16'(STB_HI + STB_LO - 1);
  localparam logic [9:0]  SECTOR    = 10'd512;
  localparam logic [9:0]  LAST_BYTE = 10'd511;

  state_t      state_q, state_d;
  logic [31:0] sd_lba_q, sd_lba_d;
  logic        sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic        io_ack_q, io_ack_d, err_q, err_d;
  logic        din_stb_q, din_stb_d, dout_stb_q, dout_stb_d;
  logic [7:0]  io_din_q, io_din_d, sd_buff_din_q, sd_buff_din_d;
  logic [9:0]  cnt_q, cnt_d, fill_cnt;
  logic [15:0] ph_q, ph_d;

  logic [7:0]  mem [512];
  logic        mem_we;
  logic [8:0]  mem_waddr, rd_idx;
  logic [7:0]  mem_wdata, rd_byte;

  assign rd_byte = mem[rd_idx];

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d       = state_q;
    sd_lba_d      = sd_lba_q;
    sd_rd_d       = sd_rd_q;
    sd_wr_d       = sd_wr_q;
    io_ack_d      = io_ack_q;
    err_d         = err_q;
    din_stb_d     = din_stb_q;
    dout_stb_d    = dout_stb_q;
    io_din_d      = io_din_q;
    sd_buff_din_d = sd_buff_din_q;
    cnt_d         = cnt_q;
    ph_d          = ph_q;
    mem_we        = 1'b0;
    mem_waddr     = sd_buff_addr;
    mem_wdata     = sd_buff_dout;
    rd_idx        = cnt_q[8:0] + 9'd1;
    fill_cnt      = (sd_buff_wr && cnt_q != SECTOR) ? cnt_q + 10'd1 : cnt_q;

    unique case (state_q)
      IDLE: begin
        if (io_rd || io_wr) begin
          sd_lba_d = io_lba;
          cnt_d    = '0;
          ph_d     = '0;
          err_d    = 1'b0;
          if (io_rd) begin
            sd_rd_d = 1'b1;
            state_d = RD_REQ;
          end else begin
            dout_stb_d = 1'b1;
            state_d    = WR_DRAIN;
          end
        end
      end
      RD_REQ: begin
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          state_d = RD_FILL;
        end
      end
      RD_FILL: begin
        mem_we = sd_buff_wr;
        cnt_d  = fill_cnt;
        if (!sd_ack) begin
          err_d   = (fill_cnt != SECTOR);
          cnt_d   = '0;
          ph_d    = '0;
          rd_idx  = 9'd0;
          // Forward a byte landing at address 0 on the very last fill cycle.
          io_din_d = (sd_buff_wr && sd_buff_addr == 9'd0) ? sd_buff_dout : rd_byte;
          state_d  = RD_STREAM;
        end
      end
      RD_STREAM: begin
        ph_d = ph_q + 16'd1;
        if (ph_q == RD_RISE) din_stb_d = 1'b1;
        if (ph_q == SLOT_END) begin
          din_stb_d = 1'b0;
          ph_d      = '0;
          if (cnt_q == LAST_BYTE) begin
            io_ack_d = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d    = cnt_q + 10'd1;
            io_din_d = rd_byte;
          end
        end
      end
      WR_DRAIN: begin
        ph_d = ph_q + 16'd1;
        if (ph_q == WR_FALL) dout_stb_d = 1'b0;
        if (ph_q == WR_SAMPLE) begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q[8:0];
          mem_wdata = io_dout;
        end
        if (ph_q == SLOT_END) begin
          ph_d = '0;
          if (cnt_q == LAST_BYTE) begin
            sd_wr_d = 1'b1;
            state_d = WR_REQ;
          end else begin
            cnt_d      = cnt_q + 10'd1;
            dout_stb_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (sd_ack) begin
          sd_wr_d = 1'b0;
          state_d = WR_SERVE;
        end
      end
      WR_SERVE: begin
        rd_idx        = sd_buff_addr;
        sd_buff_din_d = rd_byte;
        if (!sd_ack) begin
          io_ack_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        io_ack_d = 1'b0;
        state_d  = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!io_rd && !io_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sd_lba_q      <= '0;
      sd_rd_q       <= 1'b0;
      sd_wr_q       <= 1'b0;
      io_ack_q      <= 1'b0;
      err_q         <= 1'b0;
      din_stb_q     <= 1'b0;
      dout_stb_q    <= 1'b0;
      io_din_q      <= '0;
      sd_buff_din_q <= '0;
      cnt_q         <= '0;
      ph_q          <= '0;
    end else begin
      state_q       <= state_d;
      sd_lba_q      <= sd_lba_d;
      sd_rd_q       <= sd_rd_d;
      sd_wr_q       <= sd_wr_d;
      io_ack_q      <= io_ack_d;
      err_q         <= err_d;
      din_stb_q     <= din_stb_d;
      dout_stb_q    <= dout_stb_d;
      io_din_q      <= io_din_d;
      sd_buff_din_q <= sd_buff_din_d;
      cnt_q         <= cnt_d;
      ph_q          <= ph_d;
    end
  end

  // NOTE: the sector buffer is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge sysclk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign io_ack         = io_ack_q;
  assign io_din         = io_din_q;
  assign io_din_strobe  = din_stb_q;
  assign io_dout_strobe = dout_stb_q;
  assign sd_lba         = sd_lba_q;
  assign sd_rd          = sd_rd_q;
  assign sd_wr          = sd_wr_q;
  assign sd_buff_din    = sd_buff_din_q;
  assign err            = err_q;

endmodule

// File: tb/tb_scsi_sector_bridge.sv
// Self-checking bench for scsi_sector_bridge: table of directed transfers,
// hand-written reset sequence, then randomized transfers against a buffer model.
module tb_scsi_sector_bridge;
  localparam int STB_HI = 1;
  localparam int STB_LO = 1;
  localparam int SLOT   = STB_HI + STB_LO;

  logic        sysclk = 1'b0;
  logic        rst;
  logic [31:0] io_lba;
  logic        io_rd, io_wr, io_ack;
  logic [7:0]  io_din, io_dout;
  logic        io_din_strobe, io_dout_strobe;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din;
  logic        sd_buff_wr, err;

  always #5 sysclk = ~sysclk;

  scsi_sector_bridge #(.STB_HI(STB_HI), .STB_LO(STB_LO)) dut (
    .sysclk(sysclk), .rst(rst), .io_lba(io_lba), .io_rd(io_rd), .io_wr(io_wr),
    .io_ack(io_ack), .io_din(io_din), .io_din_strobe(io_din_strobe),
    .io_dout(io_dout), .io_dout_strobe(io_dout_strobe), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .err(err)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] lba;
    int          dly;
    int          nbytes;
    logic [7:0]  pat;
    int          hold;
    bit          exp_err;
    bit          exp_read;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Model of the bridge's private sector, target's source sector, storage's source bytes.
  logic [7:0] mdl [512];
  logic [7:0] tgt [512];
  logic [7:0] src [512];

  int din_pulses, din_bad, din_unstable, dout_pulses, ack_cnt, sd_rd_rises, sd_wr_rises;
  logic din_prev = 1'b0, dout_prev = 1'b0, rd_prev = 1'b0, wr_prev = 1'b0;
  logic [7:0] din_last = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    din_pulses = 0; din_bad = 0; din_unstable = 0; dout_pulses = 0;
    ack_cnt = 0; sd_rd_rises = 0; sd_wr_rises = 0;
  endtask

  // One clock step; also plays the target side and watches the strobes.
  task automatic tick();
    @(negedge sysclk);
    if (io_din_strobe && !din_prev) begin
      if (din_pulses < 512 && io_din !== mdl[din_pulses[8:0]]) din_bad++;
      if (io_din !== din_last) din_unstable++;
      din_pulses++;
    end else if (io_din_strobe && io_din !== din_last) begin
      din_unstable++;
    end
    if (io_dout_strobe && !dout_prev) begin
      io_dout = tgt[dout_pulses[8:0]];
      dout_pulses++;
    end
    if (io_ack) ack_cnt++;
    if (sd_rd && !rd_prev) sd_rd_rises++;
    if (sd_wr && !wr_prev) sd_wr_rises++;
    din_prev  = io_din_strobe;
    dout_prev = io_dout_strobe;
    rd_prev   = sd_rd;
    wr_prev   = sd_wr;
    din_last  = io_din;
  endtask

  task automatic wait_ack(input string nm);
    int c = 0;
    while (ack_cnt == 0 && c < 512 * SLOT + 64) begin
      tick();
      c++;
    end
    check({nm, ":io_ack_seen"}, 64'(ack_cnt), 64'd1);
  endtask

  task automatic do_xfer(input string nm, input vec_t v, input bit rnd);
    bit seen;
    int low, bad, stride, off, c;
    logic [8:0] a;
    clear_mon();
    io_lba = v.lba;
    io_rd  = v.rd;
    io_wr  = v.wr;
    if (v.exp_read) begin
      for (int i = 0; i < v.nbytes; i++) src[i] = rnd ? 8'($urandom) : (8'(i) ^ v.pat);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin tick(); seen = sd_rd; end
      check({nm, ":sd_rd_raised"}, 64'(seen), 64'd1);
      check({nm, ":sd_lba"}, 64'(sd_lba), 64'(v.lba));
      check({nm, ":err_cleared"}, 64'(err), 64'd0);
      io_lba = ~v.lba;
      low = 0;
      for (int i = 0; i < v.dly; i++) begin tick(); if (!sd_rd) low++; end
      check({nm, ":sd_rd_held"}, 64'(low), 64'd0);
      sd_ack = 1'b1;
      tick();
      check({nm, ":sd_rd_dropped"}, 64'(sd_rd), 64'd0);
      for (int i = 0; i < v.nbytes; i++) begin
        sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_dout = src[i]; mdl[i] = src[i];
        tick();
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      wait_ack(nm);
      check({nm, ":din_pulses"}, 64'(din_pulses), 64'd512);
      check({nm, ":din_bad_bytes"}, 64'(din_bad), 64'd0);
      check({nm, ":din_unstable"}, 64'(din_unstable), 64'd0);
      check({nm, ":err"}, 64'(err), 64'(v.exp_err));
    end else begin
      for (int k = 0; k < 512; k++) tgt[k] = rnd ? 8'($urandom) : (8'(255 - k) ^ v.pat);
      seen = 1'b0;
      for (c = 0; c < 512 * SLOT + 16 && !seen; c++) begin tick(); seen = sd_wr; end
      check({nm, ":sd_wr_raised"}, 64'(seen), 64'd1);
      check({nm, ":dout_pulses"}, 64'(dout_pulses), 64'd512);
      check({nm, ":sd_lba"}, 64'(sd_lba), 64'(v.lba));
      for (int k = 0; k < 512; k++) mdl[k] = tgt[k];
      io_lba = ~v.lba;
      low = 0;
      for (int i = 0; i < v.dly; i++) begin tick(); if (!sd_wr) low++; end
      check({nm, ":sd_wr_held"}, 64'(low), 64'd0);
      sd_ack = 1'b1;
      tick();
      check({nm, ":sd_wr_dropped"}, 64'(sd_wr), 64'd0);
      stride = rnd ? 2 * $urandom_range(0, 255) + 1 : 1;
      off    = rnd ? $urandom_range(0, 511) : 0;
      bad    = 0;
      for (int i = 0; i < 512; i++) begin
        a = 9'(i * stride + off);
        sd_buff_addr = a;
        tick();
        if (sd_buff_din !== mdl[a]) bad++;
      end
      check({nm, ":serve_bad_bytes"}, 64'(bad), 64'd0);
      sd_ack = 1'b0;
      wait_ack(nm);
      check({nm, ":dout_pulses_final"}, 64'(dout_pulses), 64'd512);
      check({nm, ":err"}, 64'(err), 64'd0);
    end
    check({nm, ":sd_lba_stable"}, 64'(sd_lba), 64'(v.lba));
    tick();
    check({nm, ":io_ack_one_cycle"}, 64'(io_ack), 64'd0);
    for (int i = 0; i < v.hold; i++) tick();
    check({nm, ":ack_count"}, 64'(ack_cnt), 64'd1);
    check({nm, ":sd_rd_requests"}, 64'(sd_rd_rises), 64'(v.exp_read));
    check({nm, ":sd_wr_requests"}, 64'(sd_wr_rises), 64'(!v.exp_read));
    check({nm, ":no_extra_din"}, 64'(din_pulses), v.exp_read ? 64'd512 : 64'd0);
    io_rd = 1'b0;
    io_wr = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    vec_t  tbl [7];
    string names [7];
    vec_t  v;
    int    c, op;

    tbl[0] = '{1'b1, 1'b0, 32'h0000_1234, 5, 512, 8'h5A, 0,  1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0007, 3, 512, 8'h00, 0,  1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0055, 2, 100, 8'hC3, 0,  1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0056, 0, 512, 8'h11, 0,  1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1, 512, 8'h22, 0,  1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0009, 4, 512, 8'h33, 20, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 32'h8000_0001, 0, 512, 8'hF0, 3,  1'b0, 1'b0};
    names  = '{"read", "write", "short_read", "after_short", "rd_wr_both", "rd_held", "write2"};

    rst = 1'b1; io_lba = '0; io_rd = 1'b0; io_wr = 1'b0; io_dout = '0;
    sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
    for (int k = 0; k < 512; k++) begin mdl[k] = 8'h00; tgt[k] = 8'h00; end
    clear_mon();
    tick();
    tick();
    check("reset:io_ack", 64'(io_ack), 64'd0);
    check("reset:io_din", 64'(io_din), 64'd0);
    check("reset:strobes", 64'({io_din_strobe, io_dout_strobe}), 64'd0);
    check("reset:sd_lba", 64'(sd_lba), 64'd0);
    check("reset:sd_rd_wr", 64'({sd_rd, sd_wr}), 64'd0);
    check("reset:sd_buff_din", 64'(sd_buff_din), 64'd0);
    check("reset:err", 64'(err), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) do_xfer(names[i], tbl[i], 1'b0);

    // Reset in the middle of streaming, right as pulse 300 is high.
    clear_mon();
    io_lba = 32'h0000_0ABC;
    io_rd  = 1'b1;
    c = 0;
    while (!sd_rd && c < 8) begin tick(); c++; end
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 512; i++) begin
      sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_dout = 8'($urandom); mdl[i] = sd_buff_dout;
      tick();
    end
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    c = 0;
    while (din_pulses < 300 && c < 512 * SLOT + 64) begin tick(); c++; end
    check("mid_reset:reached_byte_300", 64'(din_pulses), 64'd300);
    rst   = 1'b1;
    io_rd = 1'b0;
    tick();
    check("mid_reset:strobe_low", 64'(io_din_strobe), 64'd0);
    check("mid_reset:outputs_idle", 64'({io_ack, sd_rd, sd_wr, err}), 64'd0);
    check("mid_reset:io_din", 64'(io_din), 64'd0);
    check("mid_reset:sd_lba", 64'(sd_lba), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_reset:no_ack", 64'(ack_cnt), 64'd0);
    check("mid_reset:no_more_pulses", 64'(din_pulses), 64'd300);
    check("mid_reset:quiet", 64'({sd_rd, sd_wr, io_din_strobe, io_dout_strobe}), 64'd0);
    do_xfer("post_reset_read", '{1'b1, 1'b0, 32'h0000_0ABD, 2, 512, 8'h77, 0, 1'b0, 1'b1}, 1'b0);

    for (int r = 0; r < 8; r++) begin
      op         = $urandom_range(0, 2);
      v.rd       = (op != 1);
      v.wr       = (op != 0);
      v.lba      = $urandom;
      v.dly      = $urandom_range(0, 5);
      v.nbytes   = ($urandom_range(0, 1) == 1) ? 512 : $urandom_range(1, 511);
      v.pat      = 8'h00;
      v.hold     = $urandom_range(0, 3);
      v.exp_read = v.rd;
      v.exp_err  = v.rd && (v.nbytes < 512);
      do_xfer($sformatf("rand%0d", r), v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/scsi_sector_bridge.md
Name: scsi_sector_bridge

Overview:
- Sits between the SCSI target block and the card/storage controller.
- Turns the target's io_rd/io_wr block requests into sector transfers on a byte-addressed storage buffer port (sd_*).
- Paces the transfers back to the target with io_din_strobe/io_dout_strobe pulses, then answers with a one-cycle io_ack.
- Owns a private 512-byte sector buffer so either side can burst at its own rate.

Parameters:
- STB_HI, 1, cycles each io_*_strobe is held high (>=1).
- STB_LO, 1, minimum cycles each io_*_strobe is held low between pulses (>=1).

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- io_lba  in  32  sector address from the target; latched at request accept.
- io_rd  in  1  target requests sector read (level).
- io_wr  in  1  target requests sector write (level).
- io_ack  out  1  one-cycle completion pulse to the target.
- io_din  out  8  read byte to the target.
- io_din_strobe  out  1  target stores io_din on rising edge and advances its pointer on falling edge.
- io_dout  in  8  write byte from the target; updated by the target on the io_dout_strobe rising edge.
- io_dout_strobe  out  1  pulls the next write byte from the target.
- sd_lba  out  32  sector address to storage.
- sd_rd  out  1  storage read request.
- sd_wr  out  1  storage write request.
- sd_ack  in  1  storage busy/ack; high for the duration of the transfer.
- sd_buff_addr  in  9  storage byte index.
- sd_buff_dout  in  8  storage->bridge byte.
- sd_buff_wr  in  1  sd_buff_dout valid at sd_buff_addr this cycle.
- sd_buff_din  out  8  bridge->storage byte; registered, valid the cycle after sd_buff_addr.
- err  out  1  sticky: a storage transfer ended short (<512 bytes written on read); cleared at the next accepted request.

Behaviour:
- Reset values: io_ack=0, io_din=0, io_din_strobe=0, io_dout_strobe=0, sd_lba=0, sd_rd=0, sd_wr=0, sd_buff_din=0, err=0, state=IDLE, all counters 0. Buffer contents are not reset.
- Reset asserted mid-transfer aborts immediately to IDLE with all outputs at reset values; no io_ack is issued.
- IDLE:
  - io_rd=1 -> latch sd_lba<=io_lba, clear byte count and err, go RD_REQ.
  - else io_wr=1 -> latch sd_lba, go WR_DRAIN.
  - io_rd wins if both are high.
- RD_REQ: sd_rd=1 until sd_ack is sampled high, then sd_rd=0 in the same cycle and go RD_FILL.
- RD_FILL:
  - On each sd_buff_wr: buf[sd_buff_addr]<=sd_buff_dout; byte count += 1, saturating at 512.
  - sd_ack sampled low -> go RD_STREAM; err<=1 if count<512. Stale buffer bytes are streamed anyway.
- RD_STREAM:
  - For i=0..511: io_din<=buf[i] at least 1 cycle before io_din_strobe rises.
  - Each pulse is STB_HI cycles high, then STB_LO cycles low; io_din is held stable across the whole pulse.
  - After the 512th strobe falls, go DONE.
  - Exactly 512 pulses per sector, never more.
- WR_DRAIN:
  - For i=0..511: raise io_dout_strobe for STB_HI cycles. On the first low cycle after the fall, sample io_dout into buf[i]. Then STB_LO low cycles.
  - After 512 samples, go WR_REQ.
  - Byte i therefore equals the target's buffer byte i.
- WR_REQ: sd_wr=1 until sd_ack is sampled high, then sd_wr=0, go WR_SERVE.
- WR_SERVE: sd_buff_din<=buf[sd_buff_addr] every cycle (1-cycle latency, no handshake). sd_ack sampled low -> DONE.
- DONE: io_ack=1 for exactly one cycle, then go WAIT_CLR.
- WAIT_CLR:
  - Remain until io_rd=0 and io_wr=0 are sampled together. This stops the bridge re-triggering on a request the target has not yet dropped.
  - Then go IDLE. A new request may be accepted the cycle after IDLE is entered.
- io_lba changes after accept are ignored; sd_lba is stable from accept to DONE.
- sd_buff_addr wraps naturally at 9 bits; an out-of-sequence address is honoured as given.
- sd_buff_wr outside RD_FILL is ignored. sd_ack rising outside RD_REQ/WR_REQ is ignored.
- Minimum read latency (request to io_ack): 2 + storage time + 512*(STB_HI+STB_LO) + 1 cycles.

Test Plan:
- Read: io_lba=0x1234, io_rd=1; storage model acks after 5 cycles and writes bytes (addr^0x5A) for addr 0..511.
  - Required: sd_rd drops on ack; sd_lba=0x1234; exactly 512 io_din_strobe pulses with io_din=k^0x5A on pulse k; one io_ack; err=0.
- Write: target model presents io_dout=255-k on pulse k; io_wr=1, io_lba=7.
  - Required: 512 io_dout_strobe pulses, then sd_wr; storage reading addr a sees sd_buff_din=255-a one cycle later; one io_ack.
- Short read: storage writes only 100 bytes, then drops sd_ack.
  - Required: err=1; still 512 din pulses; io_ack issued; err clears on the next io_rd.
- io_rd and io_wr asserted in the same cycle.
  - Required: read path taken; sd_wr never asserted.
- io_rd held high 20 cycles after io_ack.
  - Required: no second sd_rd until io_rd is seen low, then re-asserted high.
- rst pulsed during RD_STREAM at byte 300.
  - Required: strobe low, no io_ack, state IDLE; the next io_rd completes a full 512-byte transfer.
